// File: rtl/token_fetcher_pkg.sv
// Shared token codes, item kinds, error codes and FSM encoding for the token fetcher.
// Also used by the ROM contents and the evaluator.
package token_fetcher_pkg;

  localparam logic [7:0] TOK_HASH = 8'd10;
  localparam logic [7:0] TOK_ADD  = 8'd20;
  localparam logic [7:0] TOK_SUB  = 8'd21;
  localparam logic [7:0] TOK_DIV  = 8'd22;
  localparam logic [7:0] TOK_MUL  = 8'd23;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_SYNTAX = 3'd1;
  localparam logic [2:0] ERR_BADTOK = 3'd2;
  localparam logic [2:0] ERR_OVF    = 3'd3;
  localparam logic [2:0] ERR_NOEND  = 3'd4;

  typedef enum logic [1:0] {
    KindOperand  = 2'd0,
    KindOperator = 2'd1,
    KindEnd      = 2'd2
  } tkind_e;

  typedef enum logic [2:0] {
    StIdle, StScan, StEmitNum, StEmitOp, StEmitEnd, StDone, StErr
  } state_e;

  function automatic logic is_digit(input logic [7:0] tok);
    return tok <= 8'd9;
  endfunction

  function automatic logic is_op(input logic [7:0] tok);
    return (tok >= TOK_ADD) && (tok <= TOK_MUL);
  endfunction

endpackage

// File: rtl/token_fetcher_if.sv
// Valid/ready item stream from the token fetcher to the evaluator.
interface token_fetcher_if #(
  parameter int unsigned OPW = 16
);
  import token_fetcher_pkg::*;

  logic           tvalid;
  logic           tready;
  tkind_e         tkind;
  logic [OPW-1:0] tvalue;

  modport master (output tvalid, output tkind, output tvalue, input tready);
  modport slave  (input tvalid, input tkind, input tvalue, output tready);

endinterface

// File: rtl/token_fetcher_digit_accumulator.sv
// Decimal operand accumulator: acc <= acc*10 + d, with overflow flag for the pending digit.
module token_fetcher_digit_accumulator #(
  parameter int unsigned OPW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clear,
  input  logic           i_en,
  input  logic [3:0]     i_digit,
  output logic [OPW-1:0] o_acc,
  output logic           o_ovf
);

  logic [OPW-1:0] r_acc;
  logic [OPW+3:0] w_next;

  // Four guard bits hold acc*10+9 for any OPW-bit acc.
  assign w_next = ({4'b0, r_acc} * (OPW+4)'(10)) + {{OPW{1'b0}}, i_digit};
  assign o_ovf  = |w_next[OPW+3:OPW];
  assign o_acc  = r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en && !o_ovf) begin
      r_acc <= w_next[OPW-1:0];
    end
  end

endmodule

// File: rtl/token_fetcher.sv
// Walks the token ROM from index 0 and lexes it into operand/operator/end items.
module token_fetcher
  import token_fetcher_pkg::*;
#(
  parameter int unsigned DEPTH = 100,
  parameter int unsigned OPW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic [6:0]            o_rom_index,
  input  logic [7:0]            i_rom_token,
  token_fetcher_if.master       tok,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [2:0]            o_err_code
);

  state_e         r_state, w_state_d;
  logic [6:0]     r_rom_index, w_rom_index_d;
  logic           r_have_digit, w_have_digit_d;
  logic [7:0]     r_op, w_op_d;
  logic           r_op_valid, w_op_valid_d;
  logic [2:0]     r_err_code, w_err_code_d;
  logic           r_tvalid, w_tvalid_d;
  tkind_e         r_tkind, w_tkind_d;
  logic [OPW-1:0] r_tvalue, w_tvalue_d;

  logic           w_acc_clear, w_acc_en, w_acc_ovf, w_last;
  logic [OPW-1:0] w_acc;

  token_fetcher_digit_accumulator #(.OPW(OPW)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_acc_clear),
    .i_en    (w_acc_en),
    .i_digit (i_rom_token[3:0]),
    .o_acc   (w_acc),
    .o_ovf   (w_acc_ovf)
  );

  // No room left for a terminating '#' after this slot.
  assign w_last = (r_rom_index == 7'(DEPTH - 1));

  always_comb begin
    w_state_d      = r_state;
    w_rom_index_d  = r_rom_index;
    w_have_digit_d = r_have_digit;
    w_op_d         = r_op;
    w_op_valid_d   = r_op_valid;
    w_err_code_d   = r_err_code;
    w_acc_clear    = 1'b0;
    w_acc_en       = 1'b0;

    case (r_state)
      StIdle, StDone, StErr: begin
        if (i_start) begin
          w_rom_index_d  = '0;
          w_acc_clear    = 1'b1;
          w_have_digit_d = 1'b0;
          w_op_valid_d   = 1'b0;
          w_err_code_d   = ERR_NONE;
          w_state_d      = StScan;
        end
      end
      StScan: begin
        if (is_digit(i_rom_token)) begin
          if (w_last) begin
            w_err_code_d = ERR_NOEND;
            w_state_d    = StErr;
          end else if (w_acc_ovf) begin
            w_err_code_d = ERR_OVF;
            w_state_d    = StErr;
          end else begin
            w_acc_en       = 1'b1;
            w_have_digit_d = 1'b1;
            w_rom_index_d  = r_rom_index + 7'd1;
          end
        end else if (is_op(i_rom_token)) begin
          if (!r_have_digit) begin
            w_err_code_d = ERR_SYNTAX;
            w_state_d    = StErr;
          end else if (w_last) begin
            w_err_code_d = ERR_NOEND;
            w_state_d    = StErr;
          end else begin
            w_op_d        = i_rom_token;
            w_op_valid_d  = 1'b1;
            w_rom_index_d = r_rom_index + 7'd1;
            w_state_d     = StEmitNum;
          end
        end else if (i_rom_token == TOK_HASH) begin
          if (!r_have_digit) begin
            w_err_code_d = ERR_SYNTAX;
            w_state_d    = StErr;
          end else begin
            w_op_valid_d = 1'b0;
            w_state_d    = StEmitNum;
          end
        end else begin
          w_err_code_d = ERR_BADTOK;
          w_state_d    = StErr;
        end
      end
      StEmitNum: if (tok.tready) w_state_d = r_op_valid ? StEmitOp : StEmitEnd;
      StEmitOp: begin
        if (tok.tready) begin
          w_acc_clear    = 1'b1;
          w_have_digit_d = 1'b0;
          w_state_d      = StScan;
        end
      end
      StEmitEnd: if (tok.tready) w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase

    // Item registers are loaded from the state being entered, so they hold while waiting.
    w_tvalid_d = 1'b0;
    w_tkind_d  = KindOperand;
    w_tvalue_d = '0;
    case (w_state_d)
      StEmitNum: begin
        w_tvalid_d = 1'b1;
        w_tvalue_d = w_acc;
      end
      StEmitOp: begin
        w_tvalid_d = 1'b1;
        w_tkind_d  = KindOperator;
        w_tvalue_d = OPW'(w_op_d);
      end
      StEmitEnd: begin
        w_tvalid_d = 1'b1;
        w_tkind_d  = KindEnd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_rom_index  <= '0;
      r_have_digit <= 1'b0;
      r_op         <= '0;
      r_op_valid   <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_tvalid     <= 1'b0;
      r_tkind      <= KindOperand;
      r_tvalue     <= '0;
    end else begin
      r_state      <= w_state_d;
      r_rom_index  <= w_rom_index_d;
      r_have_digit <= w_have_digit_d;
      r_op         <= w_op_d;
      r_op_valid   <= w_op_valid_d;
      r_err_code   <= w_err_code_d;
      r_tvalid     <= w_tvalid_d;
      r_tkind      <= w_tkind_d;
      r_tvalue     <= w_tvalue_d;
    end
  end

  assign o_rom_index = r_rom_index;
  assign tok.tvalid  = r_tvalid;
  assign tok.tkind   = r_tkind;
  assign tok.tvalue  = r_tvalue;
  assign o_busy      = (r_state == StScan) || (r_state == StEmitNum) ||
                       (r_state == StEmitOp) || (r_state == StEmitEnd);
  assign o_done      = (r_state == StDone);
  assign o_err       = (r_state == StErr);
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_token_fetcher.sv
// Directed bench for token_fetcher: program table plus backpressure, depth and reset sequences.
module tb_token_fetcher;

  localparam int DEPTH = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [6:0] rom_index;
  logic [7:0] rom_token;
  logic       busy, done, err;
  logic [2:0] err_code;
  logic [7:0] rom [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  token_fetcher_if #(.OPW(16)) tok_if ();

  token_fetcher #(.DEPTH(DEPTH), .OPW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .o_rom_index (rom_index),
    .i_rom_token (rom_token),
    .tok         (tok_if),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_err_code  (err_code)
  );

  always #5 clk = ~clk;

  assign rom_token = (rom_index < 7'(DEPTH)) ? rom[rom_index] : 8'hFF;

  typedef struct {
    logic [0:7][7:0]  prog;
    int               plen;
    int               nitems;
    logic [0:3][1:0]  kind;
    logic [0:3][15:0] val;
    logic             exp_err;
    logic [2:0]       exp_code;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_prog(input vec_t v);
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'd99;
    for (int i = 0; i < v.plen; i++) rom[i] = v.prog[i];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int         n;
    bit         fin;
    logic [1:0] gk[8];
    logic [15:0] gv[8];
    load_prog(v);
    tok_if.tready = 1'b1;
    pulse_start();
    n   = 0;
    fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (tok_if.tvalid && tok_if.tready) begin
        if (n < 8) begin
          gk[n] = tok_if.tkind;
          gv[n] = tok_if.tvalue;
        end
        n++;
      end
      if (done || err) fin = 1;
      else @(negedge clk);
    end
    check({name, " finished"}, 32'(fin), 1);
    check({name, " item count"}, n, v.nitems);
    for (int i = 0; i < v.nitems && i < n && i < 4; i++) begin
      check($sformatf("%s item%0d kind", name, i), 32'(gk[i]), 32'(v.kind[i]));
      check($sformatf("%s item%0d value", name, i), 32'(gv[i]), 32'(v.val[i]));
    end
    check({name, " err"}, 32'(err), 32'(v.exp_err));
    check({name, " err_code"}, 32'(err_code), 32'(v.exp_code));
    check({name, " done"}, 32'(done), 32'(!v.exp_err));
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (tok_if.tvalid) ok = 1;
      else @(negedge clk);
    end
    check({name, " tvalid arrives"}, 32'(ok), 1);
  endtask

  initial begin
    logic [1:0]  hk;
    logic [15:0] hv;
    bit          fin;

    vecs[0] = '{prog: {8'd1, 8'd0, 8'd23, 8'd2, 8'd10, 8'd0, 8'd0, 8'd0}, plen: 5, nitems: 4,
                kind: {2'd0, 2'd1, 2'd0, 2'd2}, val: {16'd10, 16'd23, 16'd2, 16'd0},
                exp_err: 1'b0, exp_code: 3'd0};
    vecs[1] = '{prog: {8'd23, 8'd5, 8'd10, 40'd0}, plen: 3, nitems: 0,
                kind: '0, val: '0, exp_err: 1'b1, exp_code: 3'd1};
    vecs[2] = '{prog: {8'd5, 8'd20, 8'd10, 40'd0}, plen: 3, nitems: 2,
                kind: {2'd0, 2'd1, 2'd0, 2'd0}, val: {16'd5, 16'd20, 16'd0, 16'd0},
                exp_err: 1'b1, exp_code: 3'd1};
    vecs[3] = '{prog: {8'd6, 8'd5, 8'd5, 8'd3, 8'd5, 8'd10, 16'd0}, plen: 6, nitems: 2,
                kind: {2'd0, 2'd2, 2'd0, 2'd0}, val: {16'd65535, 16'd0, 16'd0, 16'd0},
                exp_err: 1'b0, exp_code: 3'd0};
    vecs[4] = '{prog: {8'd6, 8'd5, 8'd5, 8'd3, 8'd6, 8'd10, 16'd0}, plen: 6, nitems: 0,
                kind: '0, val: '0, exp_err: 1'b1, exp_code: 3'd3};
    vecs[5] = '{prog: {8'd4, 8'd15, 48'd0}, plen: 2, nitems: 0,
                kind: '0, val: '0, exp_err: 1'b1, exp_code: 3'd2};
    vecs[6] = '{prog: {8'd0, 8'd0, 8'd7, 8'd21, 8'd3, 8'd10, 16'd0}, plen: 6, nitems: 4,
                kind: {2'd0, 2'd1, 2'd0, 2'd2}, val: {16'd7, 16'd21, 16'd3, 16'd0},
                exp_err: 1'b0, exp_code: 3'd0};
    vecs[7] = '{prog: {8'd10, 56'd0}, plen: 1, nitems: 0,
                kind: '0, val: '0, exp_err: 1'b1, exp_code: 3'd1};
    vecs[8] = '{prog: {8'd1, 8'd2, 8'd22, 8'd10, 32'd0}, plen: 4, nitems: 2,
                kind: {2'd0, 2'd1, 2'd0, 2'd0}, val: {16'd12, 16'd22, 16'd0, 16'd0},
                exp_err: 1'b1, exp_code: 3'd1};

    tok_if.tready = 1'b1;
    load_prog(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset tvalid", 32'(tok_if.tvalid), 0);
    check("reset tkind", 32'(tok_if.tkind), 0);
    check("reset tvalue", 32'(tok_if.tvalue), 0);
    check("reset rom_index", 32'(rom_index), 0);
    check("reset busy/done/err", {29'd0, busy, done, err}, 0);
    check("reset err_code", 32'(err_code), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Latency: start captured, two digits, then the operator edge raises tvalid.
    load_prog(vecs[0]);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("latency tvalid low before", 32'(tok_if.tvalid), 0);
    @(negedge clk);
    check("latency tvalid high", 32'(tok_if.tvalid), 1);
    check("latency first value", 32'(tok_if.tvalue), 10);
    fin = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      if (done) fin = 1;
      else @(negedge clk);
    end
    check("latency drain done", 32'(fin), 1);

    // Backpressure: each item held three cycles before acceptance.
    tok_if.tready = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_valid($sformatf("bp item%0d", i));
      hk = tok_if.tkind;
      hv = tok_if.tvalue;
      check($sformatf("bp item%0d kind", i), 32'(hk), 32'(vecs[0].kind[i]));
      check($sformatf("bp item%0d value", i), 32'(hv), 32'(vecs[0].val[i]));
      repeat (2) begin
        @(negedge clk);
        check($sformatf("bp item%0d held", i),
              {13'd0, tok_if.tvalid, tok_if.tkind, tok_if.tvalue}, {13'd0, 1'b1, hk, hv});
      end
      tok_if.tready = 1'b1;
      @(negedge clk);
      tok_if.tready = 1'b0;
      if (i < 3) check($sformatf("bp item%0d advanced", i),
                       32'({tok_if.tkind, tok_if.tvalue} != {hk, hv} || !tok_if.tvalid), 1);
    end
    check("bp done", 32'(done), 1);
    check("bp no extra tvalid", 32'(tok_if.tvalid), 0);

    // No terminator: index stops at the last slot instead of wrapping.
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'd0;
    tok_if.tready = 1'b1;
    pulse_start();
    fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (err) fin = 1;
      else @(negedge clk);
    end
    check("noend err", 32'(fin), 1);
    check("noend err_code", 32'(err_code), 4);
    check("noend rom_index", 32'(rom_index), DEPTH - 1);
    repeat (2) @(negedge clk);
    check("noend held", {28'd0, err, err_code}, {28'd0, 1'b1, 3'd4});
    run_vec(vecs[0], "rescan after noend");

    // Reset while an operator item waits for acceptance.
    load_prog(vecs[0]);
    tok_if.tready = 1'b0;
    pulse_start();
    wait_valid("rst operand");
    tok_if.tready = 1'b1;
    @(negedge clk);
    tok_if.tready = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start ignored while emitting",
          {13'd0, tok_if.tvalid, tok_if.tkind, tok_if.tvalue}, {13'd0, 1'b1, 2'd1, 16'd23});
    #2 rst = 1'b1;
    #1;
    check("rst tvalid", 32'(tok_if.tvalid), 0);
    check("rst rom_index", 32'(rom_index), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst idle", {29'd0, busy, done, err}, 0);
    run_vec(vecs[0], "rerun after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
